receptor_nota_buzzer: RTL and testbench

Receiver end of the 3-bit note interface (`arduino_out` code plus `activateArduino` strobe) that the game core drives. It decodes each received note code, plays the corresponding tone as a square wave on an on-board buzzer pin for a fixed duration, then inserts a silent gap. It sits beside the game top level on the same clock, so the audio path works with or without the external Arduino.

---
 rtl/receptor_nota_buzzer.sv | 170 +++++++++++++++++
 tb/tb_receptor_nota_buzzer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/receptor_nota_buzzer.sv
// rtl/receptor_nota_buzzer.sv - note receiver that plays each received code as a square wave on a buzzer
// Optional post-note silent gap with one-entry pending buffer: define RECEPTOR_PAUSA_EN.
module receptor_nota_buzzer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DURACAO_MS = 500,
  parameter int PAUSA_MS   = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] nota,
  input  logic       valido,
  output logic       buzzer,
  output logic       tocando,
  output logic [2:0] nota_atual,
  output logic       fim_nota,
  output logic [1:0] db_estado
);

  localparam longint DUR_CYC = (longint'(DURACAO_MS) * longint'(CLK_HZ)) / 1000;
  localparam longint GAP_CYC = (longint'(PAUSA_MS) * longint'(CLK_HZ)) / 1000;
  // Duration and gap counters share one width so their terminal compares line up.
  localparam longint CNT_MAX = (DUR_CYC > GAP_CYC) ? DUR_CYC : GAP_CYC;
  localparam int     CW      = $clog2(CNT_MAX) + 1;
  localparam int     HW      = $clog2(CLK_HZ / (2 * 262)) + 1;
  localparam logic [CW-1:0] DUR_LAST = CW'(DUR_CYC - 1);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] TOCANDO = 2'd1;
  localparam logic [1:0] PAUSA   = 2'd2;

  function automatic logic [HW-1:0] half_last(input logic [2:0] n);
    case (n)
      3'd1:    half_last = HW'(CLK_HZ / (2 * 262) - 1);
      3'd2:    half_last = HW'(CLK_HZ / (2 * 294) - 1);
      3'd3:    half_last = HW'(CLK_HZ / (2 * 330) - 1);
      3'd4:    half_last = HW'(CLK_HZ / (2 * 349) - 1);
      3'd5:    half_last = HW'(CLK_HZ / (2 * 392) - 1);
      3'd6:    half_last = HW'(CLK_HZ / (2 * 440) - 1);
      3'd7:    half_last = HW'(CLK_HZ / (2 * 494) - 1);
      default: half_last = '0;
    endcase
  endfunction

  logic [1:0]    estado_q, estado_d;
  logic          buzzer_q, buzzer_d;
  logic          tocando_q, tocando_d;
  logic [2:0]    nota_q, nota_d;
  logic          fim_q, fim_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          start;
  logic [2:0]    start_code;
`ifdef RECEPTOR_PAUSA_EN
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  logic [CW-1:0] gcnt_q, gcnt_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    gap_code;
`endif

  always_comb begin
    estado_d   = estado_q;
    buzzer_d   = buzzer_q;
    tocando_d  = tocando_q;
    nota_d     = nota_q;
    fim_d      = 1'b0;
    hcnt_d     = hcnt_q;
    dcnt_d     = dcnt_q;
    start      = 1'b0;
    start_code = nota;
`ifdef RECEPTOR_PAUSA_EN
    gcnt_d     = gcnt_q;
    pend_d     = pend_q;
    gap_code   = valido ? nota : pend_q;
`endif
    case (estado_q)
      OCIOSO: begin
        start = valido && (nota != 3'd0);
      end
      TOCANDO: begin
        if (valido) begin
          // A strobe always wins over completion: nonzero retriggers, zero aborts silently.
          start = (nota != 3'd0);
          if (nota == 3'd0) begin
            estado_d  = OCIOSO;
            buzzer_d  = 1'b0;
            tocando_d = 1'b0;
            nota_d    = 3'd0;
          end
        end else if (dcnt_q == DUR_LAST) begin
          buzzer_d  = 1'b0;
          tocando_d = 1'b0;
          nota_d    = 3'd0;
          fim_d     = 1'b1;
`ifdef RECEPTOR_PAUSA_EN
          estado_d  = PAUSA;
          gcnt_d    = '0;
          pend_d    = 3'd0;
`else
          estado_d  = OCIOSO;
`endif
        end else begin
          dcnt_d = dcnt_q + 1'b1;
          if (hcnt_q == half_last(nota_q)) begin
            hcnt_d   = '0;
            buzzer_d = ~buzzer_q;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
`ifdef RECEPTOR_PAUSA_EN
      PAUSA: begin
        if (gcnt_q == GAP_LAST) begin
          pend_d     = 3'd0;
          start_code = gap_code;
          start      = (gap_code != 3'd0);
          if (gap_code == 3'd0) estado_d = OCIOSO;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
          if (valido) pend_d = nota;
        end
      end
`endif
      default: estado_d = OCIOSO;
    endcase
    if (start) begin
      estado_d  = TOCANDO;
      buzzer_d  = 1'b1;
      tocando_d = 1'b1;
      nota_d    = start_code;
      hcnt_d    = '0;
      dcnt_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      buzzer_q  <= 1'b0;
      tocando_q <= 1'b0;
      nota_q    <= 3'd0;
      fim_q     <= 1'b0;
      hcnt_q    <= '0;
      dcnt_q    <= '0;
`ifdef RECEPTOR_PAUSA_EN
      gcnt_q    <= '0;
      pend_q    <= 3'd0;
`endif
    end else begin
      estado_q  <= estado_d;
      buzzer_q  <= buzzer_d;
      tocando_q <= tocando_d;
      nota_q    <= nota_d;
      fim_q     <= fim_d;
      hcnt_q    <= hcnt_d;
      dcnt_q    <= dcnt_d;
`ifdef RECEPTOR_PAUSA_EN
      gcnt_q    <= gcnt_d;
      pend_q    <= pend_d;
`endif
    end
  end

  assign buzzer     = buzzer_q;
  assign tocando    = tocando_q;
  assign nota_atual = nota_q;
  assign fim_nota   = fim_q;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_receptor_nota_buzzer.sv
// tb/tb_receptor_nota_buzzer.sv - self-checking bench for receptor_nota_buzzer
// Honours RECEPTOR_PAUSA_EN so the same bench covers both builds.
module tb_receptor_nota_buzzer;

  localparam int CLK_HZ = 100_000;
  localparam int DUR_MS = 2;
  localparam int PAU_MS = 1;
  localparam int D      = DUR_MS * CLK_HZ / 1000;
  localparam int G      = PAU_MS * CLK_HZ / 1000;
`ifdef RECEPTOR_PAUSA_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam logic [1:0] DB2 = PEN ? 2'd2 : 2'd0;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] nota = 3'd0;
  logic       valido = 1'b0;
  logic       buzzer, tocando, fim_nota;
  logic [2:0] nota_atual;
  logic [1:0] db_estado;
  logic [7:0] act;

  receptor_nota_buzzer #(
    .CLK_HZ(CLK_HZ), .DURACAO_MS(DUR_MS), .PAUSA_MS(PAU_MS)
  ) dut (
    .clock(clock), .reset(reset), .nota(nota), .valido(valido),
    .buzzer(buzzer), .tocando(tocando), .nota_atual(nota_atual),
    .fim_nota(fim_nota), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  assign act = {buzzer, tocando, nota_atual, fim_nota, db_estado};

  int checks = 0;
  int errors = 0;

  // Reference model: note start time, pause start time, pending code.
  int e = 0;
  int m_st = 0;
  int m_note = 0;
  int m_t0 = 0;
  int m_p0 = 0;
  int m_pend = 0;
  int m_fim_e = -1;

  typedef struct {
    int         gap;
    bit         v;
    logic [2:0] n;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic int hp(input int n);
    int f;
    case (n)
      1: f = 262; 2: f = 294; 3: f = 330; 4: f = 349;
      5: f = 392; 6: f = 440; 7: f = 494; default: f = 0;
    endcase
    return (f == 0) ? 1 : CLK_HZ / (2 * f);
  endfunction

  function automatic logic [7:0] pk(input bit b, input bit t, input int na, input bit f, input logic [1:0] db);
    logic [2:0] na3;
    na3 = 3'(na);
    return {b, t, na3, f, db};
  endfunction

  function automatic vec_t mk(input int gap, input bit v, input int n, input logic [7:0] exp);
    vec_t r;
    r.gap = gap; r.v = v; r.n = 3'(n); r.exp = exp;
    return r;
  endfunction

  function automatic void m_start(input int code);
    m_st = 1; m_note = code; m_t0 = e;
  endfunction

  function automatic void model_edge(input bit v, input int n);
    int code;
    case (m_st)
      0: if (v && n != 0) m_start(n);
      1: begin
        if (v) begin
          if (n != 0) m_start(n); else m_st = 0;
        end else if (e - m_t0 == D) begin
          m_fim_e = e; m_st = PEN ? 2 : 0; m_p0 = e; m_pend = 0;
        end
      end
      default: begin
        if (e - m_p0 == G) begin
          code = v ? n : m_pend;
          m_pend = 0;
          if (code != 0) m_start(code); else m_st = 0;
        end else if (v) begin
          m_pend = n;
        end
      end
    endcase
  endfunction

  function automatic logic [7:0] model_out();
    bit b;
    b = (m_st == 1) && (((e - m_t0) / hp(m_note)) % 2 == 0);
    return pk(b, m_st == 1, (m_st == 1) ? m_note : 0, m_fim_e == e, 2'(m_st));
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got {buz,toc,nota,fim,db}=%b, required %b", name, e, got, exp);
    end
  endtask

  task automatic step(input bit v, input logic [2:0] n);
    valido = v;
    nota   = n;
    @(posedge clock);
    e++;
    model_edge(v, int'(n));
    #1;
    check("model", act, model_out());
  endtask

  initial begin
    // Scenario tables: each entry idles gap-1 edges, then applies its strobe on the gap-th edge.
    vecs.push_back(mk(400, 0, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(1,   1, 6, pk(1,1,6,0,1)));
    vecs.push_back(mk(112, 0, 0, pk(1,1,6,0,1)));
    vecs.push_back(mk(1,   0, 0, pk(0,1,6,0,1)));
    vecs.push_back(mk(86,  0, 0, pk(0,1,6,0,1)));
    vecs.push_back(mk(1,   0, 0, pk(0,0,0,1,DB2)));
    vecs.push_back(mk(1,   0, 0, pk(0,0,0,0,DB2)));
    vecs.push_back(mk(98,  0, 0, pk(0,0,0,0,DB2)));
    vecs.push_back(mk(1,   0, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(50,  0, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(1,   1, 1, pk(1,1,1,0,1)));
    vecs.push_back(mk(150, 1, 3, pk(1,1,3,0,1)));
    vecs.push_back(mk(50,  0, 0, pk(1,1,3,0,1)));
    vecs.push_back(mk(149, 0, 0, pk(0,1,3,0,1)));
    vecs.push_back(mk(1,   0, 0, pk(0,0,0,1,DB2)));
    vecs.push_back(mk(400, 0, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(1,   1, 5, pk(1,1,5,0,1)));
    vecs.push_back(mk(50,  1, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(150, 0, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(1,   1, 2, pk(1,1,2,0,1)));
    vecs.push_back(mk(200, 0, 0, pk(0,0,0,1,DB2)));
    vecs.push_back(mk(20,  1, 4, PEN ? pk(0,0,0,0,2) : pk(1,1,4,0,1)));
    vecs.push_back(mk(30,  1, 7, PEN ? pk(0,0,0,0,2) : pk(1,1,7,0,1)));
    vecs.push_back(mk(49,  0, 0, PEN ? pk(0,0,0,0,2) : pk(1,1,7,0,1)));
    vecs.push_back(mk(1,   0, 0, pk(1,1,7,0,1)));
    vecs.push_back(mk(400, 0, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(1,   1, 1, pk(1,1,1,0,1)));
    vecs.push_back(mk(200, 1, 3, pk(1,1,3,0,1)));
    vecs.push_back(mk(1,   0, 0, pk(1,1,3,0,1)));
    vecs.push_back(mk(198, 0, 0, pk(0,1,3,0,1)));
    vecs.push_back(mk(1,   0, 0, pk(0,0,0,1,DB2)));
    vecs.push_back(mk(400, 0, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(1,   1, 1, pk(1,1,1,0,1)));
    vecs.push_back(mk(250, 1, 5, PEN ? pk(0,0,0,0,2) : pk(1,1,5,0,1)));
    vecs.push_back(mk(50,  1, 0, pk(0,0,0,0,0)));
    vecs.push_back(mk(300, 0, 0, pk(0,0,0,0,0)));

    #12;
    check("reset_state", act, 8'h00);
    @(negedge clock);
    reset = 1'b1;

    // Reset in the middle of a note, then a normal start.
    step(1'b1, 3'd6);
    repeat (50) step(1'b0, 3'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_async", act, 8'h00);
    @(posedge clock);
    #1;
    check("reset_hold", act, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    m_st = 0; m_pend = 0; m_note = 0;
    step(1'b1, 3'd2);
    check("after_reset_start", act, pk(1,1,2,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 1; j < vecs[i].gap; j++) step(1'b0, 3'd0);
      step(vecs[i].v, vecs[i].n);
      check($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 39) == 0, 3'($urandom_range(0, 7)));
    end
    repeat (400) step(1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
